// File: rtl/d_kes_pe_elu_sern_pkg.sv
// Shared definitions for the KES error-locator-update processing element.
package d_kes_pe_elu_sern_pkg;

  // Default field: GF(2^12), x^12 + x^6 + x^4 + x + 1 (leading term implied).
  localparam int unsigned DefGfOrder = 12;
  localparam logic [DefGfOrder-1:0] DefPrimPoly = 12'h053;

  // One-hot update sequencer states.
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StRun  = 3'b010,
    StDone = 3'b100
  } elu_state_e;

  // Field zero/one; cast to the field width at the point of use.
  localparam int unsigned GfZero = 0;
  localparam int unsigned GfOne  = 1;

endpackage

// File: rtl/d_kes_pe_elu_sern_gf_mult.sv
// Combinational GF(2^m) polynomial-basis multiplier, reduced by PRIM_POLY.
module d_kes_pe_elu_sern_gf_mult
  import d_kes_pe_elu_sern_pkg::*;
#(
  parameter int unsigned           GF_ORDER  = DefGfOrder,
  parameter logic [GF_ORDER-1:0]   PRIM_POLY = DefPrimPoly
) (
  input  logic [GF_ORDER-1:0] i_a,
  input  logic [GF_ORDER-1:0] i_b,
  output logic [GF_ORDER-1:0] o_p
);

  logic [GF_ORDER-1:0] a_sh;

  // Shift-and-add: a_sh walks through a*x^i mod P(x), accumulated where b[i] is set.
  always_comb begin
    o_p  = '0;
    a_sh = i_a;
    for (int i = 0; i < GF_ORDER; i++) begin
      if (i_b[i]) o_p = o_p ^ a_sh;
      a_sh = {a_sh[GF_ORDER-2:0], 1'b0} ^ (a_sh[GF_ORDER-1] ? PRIM_POLY : '0);
    end
  end

endmodule

// File: rtl/d_kes_pe_elu_sern.sv
// Time-multiplexed ELU processing element: owns NCOEF coefficients of v(X) and k(X)
// and updates them one per cycle, highest index first, with two shared multipliers.
module d_kes_pe_elu_sern
  import d_kes_pe_elu_sern_pkg::*;
#(
  parameter int unsigned         GF_ORDER  = DefGfOrder,
  parameter int unsigned         NCOEF     = 4,
  parameter logic [GF_ORDER-1:0] PRIM_POLY = DefPrimPoly,
  parameter bit                  IS_LOWEST = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_RESET_KES_n,
  input  logic                      i_stop_dec,
  input  logic                      i_init,
  input  logic                      i_execute,
  input  logic [GF_ORDER-1:0]       i_delta_2im2,
  input  logic [GF_ORDER-1:0]       i_d_2i,
  input  logic                      i_condition_2i,
  input  logic [GF_ORDER-1:0]       i_v_Xm1,
  input  logic [GF_ORDER-1:0]       i_k_Xm1,
  output logic [GF_ORDER-1:0]       o_v_top,
  output logic [GF_ORDER-1:0]       o_k_top,
  output logic [NCOEF*GF_ORDER-1:0] o_v_coef,
  output logic [NCOEF-1:0]          o_v_deg_chk,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned IdxW = $clog2(NCOEF);
  typedef logic [GF_ORDER-1:0] gf_t;

  gf_t        v_q [NCOEF];
  gf_t        v_d [NCOEF];
  gf_t        k_q [NCOEF];
  gf_t        k_d [NCOEF];
  gf_t        delta_q, delta_d, d_q, d_d, vx_q, vx_d, kx_q, kx_d;
  logic       cond_q, cond_d;
  logic [IdxW-1:0] idx_q, idx_d;
  elu_state_e state_q, state_d;

  gf_t op_v, op_vs, op_ks, prod_v, prod_k;

  // Operand select for the coefficient being updated; j==0 takes the neighbour's captured top.
  always_comb begin
    op_v  = gf_t'(GfZero);
    op_vs = vx_q;
    op_ks = kx_q;
    for (int j = 0; j < NCOEF; j++) begin
      if (idx_q == IdxW'(j)) begin
        op_v = v_q[j];
        if (j > 0) begin
          op_vs = v_q[(j > 0) ? j - 1 : 0];
          op_ks = k_q[(j > 0) ? j - 1 : 0];
        end
      end
    end
  end

  d_kes_pe_elu_sern_gf_mult #(
    .GF_ORDER  (GF_ORDER),
    .PRIM_POLY (PRIM_POLY)
  ) u_mult_v (
    .i_a (delta_q),
    .i_b (op_v),
    .o_p (prod_v)
  );

  d_kes_pe_elu_sern_gf_mult #(
    .GF_ORDER  (GF_ORDER),
    .PRIM_POLY (PRIM_POLY)
  ) u_mult_k (
    .i_a (d_q),
    .i_b (op_ks),
    .o_p (prod_k)
  );

  // Sequencer and register next-state; stop_dec overrides everything last.
  always_comb begin
    v_d     = v_q;
    k_d     = k_q;
    delta_d = delta_q;
    d_d     = d_q;
    cond_d  = cond_q;
    vx_d    = vx_q;
    kx_d    = kx_q;
    idx_d   = idx_q;
    state_d = state_q;

    unique case (state_q)
      StIdle: begin
        if (i_init) begin
          for (int j = 0; j < NCOEF; j++) begin
            v_d[j] = gf_t'(GfZero);
            k_d[j] = gf_t'(GfZero);
          end
          if (IS_LOWEST) begin
            v_d[0] = gf_t'(GfOne);
            k_d[0] = gf_t'(GfOne);
          end
        end else if (i_execute) begin
          delta_d = i_delta_2im2;
          d_d     = i_d_2i;
          cond_d  = i_condition_2i;
          vx_d    = i_v_Xm1;
          kx_d    = i_k_Xm1;
          idx_d   = IdxW'(NCOEF - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        for (int j = 0; j < NCOEF; j++) begin
          if (idx_q == IdxW'(j)) begin
            v_d[j] = prod_v ^ prod_k;
            k_d[j] = cond_q ? op_vs : gf_t'(GfZero);
          end
        end
        if (idx_q == '0) state_d = StDone;
        else             idx_d   = idx_q - 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (i_stop_dec) begin
      for (int j = 0; j < NCOEF; j++) begin
        v_d[j] = gf_t'(GfZero);
        k_d[j] = gf_t'(GfZero);
      end
      delta_d = gf_t'(GfZero);
      d_d     = gf_t'(GfZero);
      cond_d  = 1'b0;
      vx_d    = gf_t'(GfZero);
      kx_d    = gf_t'(GfZero);
      idx_d   = '0;
      state_d = StIdle;
    end
  end

  // State and coefficient registers.
  always_ff @(posedge i_clk or negedge i_RESET_KES_n) begin
    if (!i_RESET_KES_n) begin
      for (int j = 0; j < NCOEF; j++) begin
        v_q[j] <= '0;
        k_q[j] <= '0;
      end
      delta_q <= '0;
      d_q     <= '0;
      cond_q  <= 1'b0;
      vx_q    <= '0;
      kx_q    <= '0;
      idx_q   <= '0;
      state_q <= StIdle;
    end else begin
      v_q     <= v_d;
      k_q     <= k_d;
      delta_q <= delta_d;
      d_q     <= d_d;
      cond_q  <= cond_d;
      vx_q    <= vx_d;
      kx_q    <= kx_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // Output packing and per-coefficient nonzero flags.
  always_comb begin
    o_v_coef    = '0;
    o_v_deg_chk = '0;
    for (int j = 0; j < NCOEF; j++) begin
      o_v_coef[j*GF_ORDER +: GF_ORDER] = v_q[j];
      o_v_deg_chk[j]                   = |v_q[j];
    end
  end

  assign o_v_top = v_q[NCOEF-1];
  assign o_k_top = k_q[NCOEF-1];
  assign o_busy  = (state_q == StRun);
  assign o_done  = (state_q == StDone);

endmodule

// File: tb/tb_d_kes_pe_elu_sern.sv
// Bench for two chained ELU elements (lower holds X^0..X^3, upper X^4..X^7).
module tb_d_kes_pe_elu_sern;

  localparam int M = 12;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic stop_dec, init, execute, cond;
  logic [M-1:0] delta, d, vx, kx;

  logic [M-1:0]   lo_v_top, lo_k_top, up_v_top, up_k_top;
  logic [N*M-1:0] lo_v_coef, up_v_coef;
  logic [N-1:0]   lo_deg, up_deg;
  logic           lo_busy, lo_done, up_busy, up_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  d_kes_pe_elu_sern #(.GF_ORDER(M), .NCOEF(N), .PRIM_POLY(12'h053), .IS_LOWEST(1'b1)) u_lo (
    .i_clk          (clk),
    .i_RESET_KES_n  (rst_n),
    .i_stop_dec     (stop_dec),
    .i_init         (init),
    .i_execute      (execute),
    .i_delta_2im2   (delta),
    .i_d_2i         (d),
    .i_condition_2i (cond),
    .i_v_Xm1        (vx),
    .i_k_Xm1        (kx),
    .o_v_top        (lo_v_top),
    .o_k_top        (lo_k_top),
    .o_v_coef       (lo_v_coef),
    .o_v_deg_chk    (lo_deg),
    .o_busy         (lo_busy),
    .o_done         (lo_done)
  );

  d_kes_pe_elu_sern #(.GF_ORDER(M), .NCOEF(N), .PRIM_POLY(12'h053), .IS_LOWEST(1'b0)) u_up (
    .i_clk          (clk),
    .i_RESET_KES_n  (rst_n),
    .i_stop_dec     (stop_dec),
    .i_init         (init),
    .i_execute      (execute),
    .i_delta_2im2   (delta),
    .i_d_2i         (d),
    .i_condition_2i (cond),
    .i_v_Xm1        (lo_v_top),
    .i_k_Xm1        (lo_k_top),
    .o_v_top        (up_v_top),
    .o_k_top        (up_k_top),
    .o_v_coef       (up_v_coef),
    .o_v_deg_chk    (up_deg),
    .o_busy         (up_busy),
    .o_done         (up_done)
  );

  task automatic chk(input string name, input logic [N*M-1:0] act, input logic [N*M-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---- Behavioural model: the whole 8-term polynomial pair, updated atomically ----
  logic [M-1:0] mv [2*N];
  logic [M-1:0] mk [2*N];
  int           r;  // 0 = idle, 1..N busy cycles, N+1 done cycle

  // Carry-less product then long division by the full primitive polynomial.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] p;
    p = '0;
    for (int i = 0; i < M; i++) if (b[i]) p = p ^ ((2*M-1)'(a) << i);
    for (int i = 2*M-2; i >= M; i--) if (p[i]) p = p ^ ((2*M-1)'(13'h1053) << (i - M));
    return p[M-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2*N; j++) begin mv[j] <= '0; mk[j] <= '0; end
      r <= 0;
    end else if (stop_dec) begin
      for (int j = 0; j < 2*N; j++) begin mv[j] <= '0; mk[j] <= '0; end
      r <= 0;
    end else if (r == 0) begin
      if (init) begin
        for (int j = 0; j < 2*N; j++) begin mv[j] <= '0; mk[j] <= '0; end
        mv[0] <= 12'h001;
        mk[0] <= 12'h001;
      end else if (execute) begin
        for (int j = 0; j < 2*N; j++) begin
          mv[j] <= gf_mul(delta, mv[j]) ^ gf_mul(d, (j == 0) ? kx : mk[(j == 0) ? 0 : j - 1]);
          mk[j] <= cond ? ((j == 0) ? vx : mv[(j == 0) ? 0 : j - 1]) : '0;
        end
        r <= 1;
      end
    end else begin
      r <= (r == N + 1) ? 0 : r + 1;
    end
  end

  function automatic logic [N*M-1:0] pack_v(input int base);
    logic [N*M-1:0] p;
    for (int j = 0; j < N; j++) p[j*M +: M] = mv[base + j];
    return p;
  endfunction

  function automatic logic [N-1:0] deg_v(input int base);
    logic [N-1:0] b;
    for (int j = 0; j < N; j++) b[j] = |mv[base + j];
    return b;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("lo_busy", {47'd0, lo_busy}, {47'd0, (r >= 1 && r <= N)});
      chk("up_busy", {47'd0, up_busy}, {47'd0, (r >= 1 && r <= N)});
      chk("lo_done", {47'd0, lo_done}, {47'd0, (r == N + 1)});
      chk("up_done", {47'd0, up_done}, {47'd0, (r == N + 1)});
      // Tops are written at the first RUN edge, so only the first busy cycle shows old values.
      if (r != 1) begin
        chk("lo_v_top", {36'd0, lo_v_top}, {36'd0, mv[N-1]});
        chk("lo_k_top", {36'd0, lo_k_top}, {36'd0, mk[N-1]});
        chk("up_v_top", {36'd0, up_v_top}, {36'd0, mv[2*N-1]});
        chk("up_k_top", {36'd0, up_k_top}, {36'd0, mk[2*N-1]});
      end
      if (!(r >= 1 && r <= N)) begin
        chk("lo_v_coef", lo_v_coef, pack_v(0));
        chk("up_v_coef", up_v_coef, pack_v(N));
        chk("lo_deg", {44'd0, lo_deg}, {44'd0, deg_v(0)});
        chk("up_deg", {44'd0, up_deg}, {44'd0, deg_v(N)});
      end
    end
  end

  // ---- Directed stimulus ----
  task automatic do_init();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  // Launch one update, scramble the data inputs afterwards, and measure latency to o_done.
  task automatic run_exec(input logic [M-1:0] de, input logic [M-1:0] dd, input logic c,
                          input logic [M-1:0] v, input logic [M-1:0] k, input bit poke);
    int n;
    @(negedge clk);
    delta = de; d = dd; cond = c; vx = v; kx = k;
    execute = 1'b1;
    @(negedge clk);
    execute = 1'b0;
    delta = 12'hFFF; d = 12'hFFF; cond = ~c; vx = 12'hFFF; kx = 12'hFFF;
    n = 1;
    while (!lo_done && n < 20) begin
      @(negedge clk);
      n++;
      if (poke) execute = (n == 2);
    end
    chk("done_latency", 48'(n), 48'(N + 1));
    if (poke) begin
      execute = 1'b1;
      @(negedge clk);
      execute = 1'b0;
      chk("exec_in_done_ignored", {47'd0, lo_busy}, 48'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; stop_dec = 1'b0; init = 1'b0; execute = 1'b0;
    delta = '0; d = '0; cond = 1'b0; vx = '0; kx = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_lo_coef", lo_v_coef, 48'd0);
    chk("rst_up_coef", up_v_coef, 48'd0);
    chk("rst_busy_done", {46'd0, lo_busy, lo_done}, 48'd0);
    chk("rst_tops", {24'd0, lo_v_top, lo_k_top}, 48'd0);

    do_init();
    chk("init_lo_coef", lo_v_coef, 48'h000000000001);
    chk("init_lo_deg", {44'd0, lo_deg}, 48'b0001);
    chk("init_busy", {47'd0, lo_busy}, 48'd0);

    run_exec(12'h001, 12'h000, 1'b1, 12'h000, 12'h000, 1'b0);
    chk("shift_k_v_kept", lo_v_coef, 48'h000000000001);

    // v[j] <- k[j-1] with k = {0,0,1,0}, v[0] <- kx
    run_exec(12'h000, 12'h001, 1'b0, 12'h000, 12'h007, 1'b0);
    chk("v_from_k", lo_v_coef, 48'h000001000007);
    chk("v_from_k_deg", {44'd0, lo_deg}, 48'b0101);
    chk("k_cleared_top", {36'd0, lo_k_top}, 48'd0);

    run_exec(12'h000, 12'h001, 1'b0, 12'h000, 12'h800, 1'b0);
    chk("load_800", lo_v_coef, 48'h000000000800);
    run_exec(12'h002, 12'h000, 1'b0, 12'h000, 12'h000, 1'b1);
    chk("mul_800x2", lo_v_coef, 48'h000000000053);
    run_exec(12'h000, 12'h001, 1'b0, 12'h000, 12'h002, 1'b0);
    run_exec(12'h002, 12'h000, 1'b0, 12'h000, 12'h000, 1'b0);
    chk("mul_2x2", lo_v_coef, 48'h000000000004);

    // Dense operands, checked by the model only.
    run_exec(12'hABC, 12'h123, 1'b1, 12'h5A5, 12'hC3C, 1'b0);
    run_exec(12'h7E1, 12'hF0F, 1'b1, 12'h001, 12'h9D2, 1'b1);
    run_exec(12'h3A7, 12'h0C5, 1'b0, 12'h111, 12'hEEE, 1'b0);

    // Chain: shift both polynomials upward across the instance boundary.
    do_init();
    chk("reinit_up_coef", up_v_coef, 48'd0);
    run_exec(12'h000, 12'h001, 1'b1, 12'h0A5, 12'h03C, 1'b0);
    repeat (4) run_exec(12'h000, 12'h001, 1'b1, 12'h000, 12'h000, 1'b0);
    chk("chain_up_v", up_v_coef, 48'h00000000103C);
    run_exec(12'h000, 12'h001, 1'b0, 12'h000, 12'h000, 1'b0);
    chk("chain_up_k0", up_v_coef, 48'h0000010A5000);
    chk("chain_up_deg", {44'd0, up_deg}, 48'b0110);

    // Abort mid-run at T+2, then restart at T+4.
    do_init();
    run_exec(12'h000, 12'h001, 1'b1, 12'h0A5, 12'h03C, 1'b0);
    @(negedge clk);
    delta = 12'h001; d = 12'h001; cond = 1'b1; vx = 12'h123; kx = 12'h456;
    execute = 1'b1;
    @(negedge clk);
    execute = 1'b0;
    @(negedge clk);
    stop_dec = 1'b1;
    @(negedge clk);
    stop_dec = 1'b0;
    chk("stop_lo_coef", lo_v_coef, 48'd0);
    chk("stop_up_coef", up_v_coef, 48'd0);
    chk("stop_busy_done", {46'd0, lo_busy, lo_done}, 48'd0);
    chk("stop_tops", {lo_v_top, lo_k_top, up_v_top, up_k_top}, 48'd0);
    run_exec(12'h001, 12'h002, 1'b1, 12'h00F, 12'h0F0, 1'b0);
    chk("restart_v", lo_v_coef, 48'h0000000001E0);

    // init and execute together: init wins.
    @(negedge clk);
    init = 1'b1; execute = 1'b1;
    @(negedge clk);
    init = 1'b0; execute = 1'b0;
    chk("init_wins_busy", {47'd0, lo_busy}, 48'd0);
    chk("init_wins_coef", lo_v_coef, 48'h000000000001);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/d_kes_pe_elu_sern.md
# d_KES_PE_ELU_serN

Parametrised, time-multiplexed error-locator-update (ELU) processing element for the BCH key-equation solver. It owns NCOEF consecutive coefficients of the error-locator polynomial v(X) and the auxiliary polynomial k(X), and updates all of them per KES iteration with one shared pair of GF(2^m) multipliers. The update runs serially over NCOEF cycles. Instances chain in ascending coefficient order to cover the full locator degree. It also adds an init mode, a start/done handshake and per-coefficient degree-check bits.

## Interface
- GF_ORDER, 12, field width m (bits per coefficient)
- NCOEF, 4, coefficients held by this instance (≥2)
- PRIM_POLY, 12'h053, low m bits of the primitive polynomial (x^12+x^6+x^4+x+1)
- IS_LOWEST, 0, 1 = instance holds coefficient X^0 (init loads 1 there)
- i_clk  in  1  clock
- i_RESET_KES_n  in  1  asynchronous, active-low reset
- i_stop_dec  in  1  synchronous abort/clear
- i_init  in  1  pulse: load initial polynomials
- i_execute  in  1  pulse: start one iteration update
- i_delta_2im2  in  m  previous discrepancy
- i_d_2i  in  m  current discrepancy
- i_condition_2i  in  1  k-update select
- i_v_Xm1  in  m  top v coefficient of the lower neighbour (0 if IS_LOWEST)
- i_k_Xm1  in  m  top k coefficient of the lower neighbour (0 if IS_LOWEST)
- o_v_top  out  m  v[NCOEF-1], feeds the upper neighbour
- o_k_top  out  m  k[NCOEF-1], feeds the upper neighbour
- o_v_coef  out  NCOEF*m  all v coefficients, v[0] in LSBs
- o_v_deg_chk  out  NCOEF  bit j = |v[j]
- o_busy  out  1  update in progress
- o_done  out  1  one-cycle pulse: update complete

## Operation
- Storage: v[0..NCOEF-1] and k[0..NCOEF-1] are m-bit registers. Capture registers hold delta, d, cond, vx and kx.
- FSM states:
  - IDLE: on i_execute, capture i_delta_2im2, i_d_2i, i_condition_2i, i_v_Xm1 and i_k_Xm1, set idx=NCOEF-1, go to RUN.
  - RUN: update coefficient idx. If idx==0, go to DONE; else decrement idx.
  - DONE: assert o_done and return to IDLE.
- Per-coefficient update at index j, where vs/ks = v[j-1]/k[j-1] for j>0 and the captured vx/kx for j=0:
  - v[j] ← (delta ⊗ v[j]) ⊕ (d ⊗ ks)
  - k[j] ← cond ? vs : 0
- Updates run from high index to low, so the j-1 operands are still pre-iteration values.
- Chained instances all start on the same i_execute. Each captures its neighbour's top values in the IDLE→RUN cycle, before any instance updates, so there is no cross-instance hazard.
- i_init, accepted only in IDLE: all v and k clear to 0. If IS_LOWEST=1, v[0]=1 and k[0]=1.
- i_execute is ignored while in RUN or DONE. i_init is ignored while in RUN or DONE.
- If i_init and i_execute arrive in the same IDLE cycle, i_init wins and the execute is dropped.
- i_stop_dec has priority over everything else:
  - all v, k and capture registers clear to 0, FSM goes to IDLE, idx=0;
  - no o_done pulse is produced for an aborted update.
- Arithmetic: ⊗ is a combinational GF(2^m) polynomial-basis multiply reduced by PRIM_POLY. ⊕ is bitwise XOR. No carries; all widths are m.
- o_v_deg_chk is a combinational OR-reduce of each register, so it is valid whenever o_busy=0.

## Timing
- Reset (async, i_RESET_KES_n=0): FSM=IDLE, idx=0, all v, k and capture registers 0. Therefore o_v_coef=0, o_v_top=0, o_k_top=0, o_v_deg_chk=0, o_busy=0, o_done=0.
- i_execute sampled high at edge T (IDLE):
  - o_busy is high for cycles T+1..T+NCOEF;
  - coefficient j holds its new value after edge T+NCOEF-j;
  - o_done is high for cycle T+NCOEF+1, during which o_busy=0;
  - total latency NCOEF+1 cycles; next i_execute is accepted at edge T+NCOEF+2.
- o_v_top and o_k_top change at edge T+1, the earliest of all coefficients. Neighbours have already captured by then.
- Inputs need only be valid at the start edge T.
- i_stop_dec taking effect at edge S: all outputs are 0 from cycle S+1.

## Structure
- Shared package/header d_KES_parameters: GF_ORDER and PRIM_POLY defaults, the FSM state encodings (IDLE, RUN, DONE; one-hot), and the zero/one constants.
- One sub-module, d_KES_GF_mult_param, with parameters GF_ORDER and PRIM_POLY: a combinational parallel multiplier. Instantiate it twice, once for delta⊗v[idx] and once for d⊗ks.
- idx-driven muxes select the operands; write-enables are decoded from idx.

## Test plan
- Reset, then i_init with IS_LOWEST=1, NCOEF=4 → o_v_coef = {0,0,0,1}, o_v_deg_chk=4'b0001, o_busy=0.
- After init, execute with delta=1, d=0, cond=1, vx=kx=0 → v unchanged, k = {0,0,1,0}. o_done is asserted exactly at T+5.
- Load v={3,2,1,1} by execute sequences, then execute with delta=0, d=1, cond=0, kx=7 → v[j] = old k[j-1], v[0]=7, k all 0.
- Multiplier check: v[0]=12'h800, delta=2, d=0 → v[0]=12'h053. With v[0]=2 and delta=2 → v[0]=4.
- Chain two instances (IS_LOWEST=1/0) on the same execute with delta=0, d=1, cond=1 → upper v[0] = lower's pre-iteration k[3], and upper k[0] = lower's pre-iteration v[3].
- Assert i_stop_dec at T+2 mid-RUN → all outputs 0 next cycle, no o_done. A new i_execute at T+4 is accepted.
